// File: rtl/accel_pkg.sv
// Shared defaults, drain FSM state type and index-width helper for the
// accelerator result drain block.
package accel_pkg;

  localparam int unsigned N_DEF = 4;
  localparam int unsigned W_DEF = 32;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } drain_state_e;

  // Width of a row-major element index for an n x n matrix (at least 1 bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n * n > 1) ? $clog2(n * n) : 1;
  endfunction

endpackage

// File: rtl/accel_idx_seq.sv
// Row/column counters walking an N x N matrix in row- or column-major order,
// reporting the row-major index of the current position.
module accel_idx_seq
  import accel_pkg::*;
#(
  parameter int unsigned N  = N_DEF,
  parameter int unsigned IW = idx_width(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          adv_i,
  input  logic          col_major_i,
  output logic [IW-1:0] idx_o,
  output logic          last_o
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] MAXC = CW'(N - 1);

  logic [CW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr_i) begin
      row_d = '0;
      col_d = '0;
    end else if (adv_i) begin
      // Column-major: row is the inner loop; row-major: column is inner.
      if (col_major_i) begin
        if (row_q == MAXC) begin
          row_d = '0;
          col_d = col_q + 1'b1;
        end else begin
          row_d = row_q + 1'b1;
        end
      end else begin
        if (col_q == MAXC) begin
          col_d = '0;
          row_d = row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign idx_o  = IW'(row_q) * IW'(N) + IW'(col_q);
  assign last_o = (row_q == MAXC) && (col_q == MAXC);

endmodule

// File: rtl/accel_result_drain.sv
// Captures an N x N accelerator result on a done rising edge and streams it
// out element by element over a valid/ready interface.
module accel_result_drain
  import accel_pkg::*;
#(
  parameter int unsigned N = N_DEF,
  parameter int unsigned W = W_DEF,
  localparam int unsigned IW = idx_width(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             done,
  input  logic [N*N*W-1:0] result_flat,
  input  logic             col_major,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [IW-1:0]    out_idx,
  output logic             out_last,
  output logic             busy,
  output logic             overrun
);

  localparam int unsigned NN = N * N;

  drain_state_e state_q, state_d;
  logic         done_q;
  logic         armed_q;
  logic         cm_q;
  logic         overrun_q, overrun_d;
  logic [W-1:0] buf_q [NN];

  logic          rise;
  logic          xfer;
  logic          capture;
  logic          seq_clr;
  logic          seq_adv;
  logic [IW-1:0] seq_idx;
  logic          seq_last;

  // armed_q blocks a done level that was already high across reset from
  // looking like a fresh edge; it sets once done has been seen low.
  assign rise = done && !done_q && armed_q;
  assign xfer = out_valid && out_ready;

  always_comb begin
    state_d   = state_q;
    overrun_d = overrun_q;
    capture   = 1'b0;
    seq_clr   = 1'b0;
    seq_adv   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          capture = 1'b1;
          seq_clr = 1'b1;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (rise) overrun_d = 1'b1;
        if (xfer) begin
          if (seq_last) state_d = ST_IDLE;
          else          seq_adv = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      done_q    <= 1'b0;
      armed_q   <= 1'b0;
      cm_q      <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      done_q    <= done;
      armed_q   <= armed_q | ~done;
      overrun_q <= overrun_d;
      if (capture) cm_q <= col_major;
    end
  end

  always_ff @(posedge clk) begin
    if (capture && !rst) begin
      for (int unsigned i = 0; i < NN; i++) begin
        buf_q[i] <= result_flat[i*W +: W];
      end
    end
  end

  accel_idx_seq #(
    .N  (N),
    .IW (IW)
  ) u_idx_seq (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (seq_clr),
    .adv_i       (seq_adv),
    .col_major_i (cm_q),
    .idx_o       (seq_idx),
    .last_o      (seq_last)
  );

  assign out_valid = (state_q == ST_DRAIN);
  assign busy      = out_valid;
  assign overrun   = overrun_q;
  assign out_data  = out_valid ? buf_q[seq_idx] : '0;
  assign out_idx   = out_valid ? seq_idx : '0;
  assign out_last  = out_valid && seq_last;

endmodule
